// File: rtl/alu_operand_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_issue_pkg
//  Description : Shared types and constants for the ID/EX operand issue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_issue_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W  = 16;
    localparam int OP_W       = 4;
    localparam int SHAMT_W    = 5;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SRA = 4'b1000;
    localparam logic [OP_W-1:0] ALU_BEQ = 4'b1001;
    localparam logic [OP_W-1:0] ALU_BNE = 4'b1010;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

    // Width-independent control half of the issue register.
    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op;
        logic               use_imm;
        logic               use_shamt;
        logic [SHAMT_W-1:0] shamt;
        logic               mem_read;
        logic               reg_write;
    } issue_ctrl_t;

    localparam issue_ctrl_t BUBBLE = '{
        valid:     1'b0,
        op:        ALU_AND,
        use_imm:   1'b0,
        use_shamt: 1'b0,
        shamt:     '0,
        mem_read:  1'b0,
        reg_write: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/alu_operand_issue_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_issue_fwd_mux
//  Description : Per-operand bypass select: EX/MEM, then MEM/WB, then RF value.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_issue_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_idx,
    input  logic              i_exm_reg_write,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [DATA_W-1:0] i_exm_result,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_idx_nz;
    logic w_hit_exm;
    logic w_hit_wb;

    // Register 0 is hard-wired, so a write to it must never be bypassed.
    always_comb begin
        w_idx_nz  = (i_idx != '0);
        w_hit_exm = w_idx_nz & i_exm_reg_write & (i_exm_rd == i_idx);
        w_hit_wb  = w_idx_nz & i_wb_reg_write  & (i_wb_rd  == i_idx);
        o_data    = i_rf_data;
        if (w_hit_exm) begin
            o_data = i_exm_result;
        end else if (w_hit_wb) begin
            o_data = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_issue
//  Description : ID/EX issue register with operand forwarding, load-use stall
//                and branch-flush bubble injection feeding the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_issue
    import alu_operand_issue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_use_shamt,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_id,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic [3:0]        ALUControl,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    issue_ctrl_t       r_ctrl_q;
    issue_ctrl_t       w_ctrl_d;
    logic [REG_AW-1:0] r_rs_q, w_rs_d;
    logic [REG_AW-1:0] r_rt_q, w_rt_d;
    logic [REG_AW-1:0] r_rd_q, w_rd_d;
    logic [DATA_W-1:0] r_rs_data_q, w_rs_data_d;
    logic [DATA_W-1:0] r_rt_data_q, w_rt_data_d;
    logic [DATA_W-1:0] r_imm_q, w_imm_d;
    logic [CNT_W-1:0]  r_bubble_cnt_q, w_bubble_cnt_d;

    logic              w_hz;
    logic              w_stall;
    logic              w_issue;
    logic              w_cnt_event;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // A load in EX cannot supply its data in time for a consumer in ID.
    // Rt only counts as a source when the immediate does not replace it.
    always_comb begin
        w_hz = r_ctrl_q.valid & r_ctrl_q.mem_read & (r_rd_q != '0) & id_valid &
               ((r_rd_q == id_rs) | ((r_rd_q == id_rt) & ~id_use_imm));
        w_stall     = w_hz & ~flush;
        w_issue     = id_valid & ~flush & ~w_stall;
        w_cnt_event = flush | w_stall;
    end

    // Flush dominates stall; either one, or an empty ID, loads a bubble.
    always_comb begin
        w_ctrl_d    = BUBBLE;
        w_rs_d      = '0;
        w_rt_d      = '0;
        w_rd_d      = '0;
        w_rs_data_d = '0;
        w_rt_data_d = '0;
        w_imm_d     = '0;
        if (w_issue) begin
            w_ctrl_d.valid     = 1'b1;
            w_ctrl_d.op        = id_alu_op;
            w_ctrl_d.use_imm   = id_use_imm;
            w_ctrl_d.use_shamt = id_use_shamt;
            w_ctrl_d.shamt     = id_shamt;
            w_ctrl_d.mem_read  = id_mem_read;
            w_ctrl_d.reg_write = id_reg_write;
            w_rs_d             = id_rs;
            w_rt_d             = id_rt;
            w_rd_d             = id_rd;
            w_rs_data_d        = id_rs_data;
            w_rt_data_d        = id_rt_data;
            w_imm_d            = id_imm;
        end
    end

    always_comb begin
        w_bubble_cnt_d = r_bubble_cnt_q;
        if (w_cnt_event && (r_bubble_cnt_q != {CNT_W{1'b1}})) begin
            w_bubble_cnt_d = r_bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ctrl_q       <= BUBBLE;
            r_rs_q         <= '0;
            r_rt_q         <= '0;
            r_rd_q         <= '0;
            r_rs_data_q    <= '0;
            r_rt_data_q    <= '0;
            r_imm_q        <= '0;
            r_bubble_cnt_q <= '0;
        end else begin
            r_ctrl_q       <= w_ctrl_d;
            r_rs_q         <= w_rs_d;
            r_rt_q         <= w_rt_d;
            r_rd_q         <= w_rd_d;
            r_rs_data_q    <= w_rs_data_d;
            r_rt_data_q    <= w_rt_data_d;
            r_imm_q        <= w_imm_d;
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    alu_operand_issue_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .i_idx           (r_rs_q),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_rd        (exm_rd),
        .i_exm_result    (exm_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .i_rf_data       (r_rs_data_q),
        .o_data          (w_fwd_rs)
    );

    alu_operand_issue_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .i_idx           (r_rt_q),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_rd        (exm_rd),
        .i_exm_result    (exm_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .i_rf_data       (r_rt_data_q),
        .o_data          (w_fwd_rt)
    );

    // Shifts take the amount on Ain, so shamt is zero-extended there.
    always_comb begin
        Ain          = r_ctrl_q.use_shamt ? {{(DATA_W-SHAMT_W){1'b0}}, r_ctrl_q.shamt} : w_fwd_rs;
        Bin          = r_ctrl_q.use_imm ? r_imm_q : w_fwd_rt;
        ALUControl   = r_ctrl_q.op;
        ex_valid     = r_ctrl_q.valid;
        ex_rd        = r_rd_q;
        ex_mem_read  = r_ctrl_q.mem_read;
        ex_reg_write = r_ctrl_q.reg_write;
        bubble_cnt   = r_bubble_cnt_q;
        stall_id     = w_stall;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_issue
//  Description : Directed and random bench for alu_operand_issue with a
//                slot-level reference model of the EX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_issue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          id_valid;
    logic [3:0]    id_alu_op;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_use_imm;
    logic [4:0]    id_shamt;
    logic          id_use_shamt, id_mem_read, id_reg_write;
    logic          flush;
    logic          exm_reg_write;
    logic [AW-1:0] exm_rd;
    logic [DW-1:0] exm_result;
    logic          wb_reg_write;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          stall_id;
    logic [DW-1:0] Ain, Bin;
    logic [3:0]    ALUControl;
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic          ex_mem_read, ex_reg_write;
    logic [CW-1:0] bubble_cnt;

    always #5 CLK = ~CLK;

    alu_operand_issue #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_shamt(id_shamt), .id_use_shamt(id_use_shamt),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_id(stall_id), .Ain(Ain), .Bin(Bin), .ALUControl(ALUControl),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .bubble_cnt(bubble_cnt)
    );

    // The instruction the model believes sits in EX (all-zero = bubble).
    typedef struct packed {
        logic          v;
        logic [3:0]    op;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] rsd, rtd, imm;
        logic          ui;
        logic [4:0]    sh;
        logic          us, mr, rw;
    } slot_t;

    slot_t       m;
    int unsigned m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] idx, input logic [DW-1:0] rfv);
        if (idx == 0) return rfv;
        if (exm_reg_write && exm_rd == idx) return exm_result;
        if (wb_reg_write && wb_rd == idx) return wb_data;
        return rfv;
    endfunction

    function automatic logic exp_stall();
        logic reads_rt;
        reads_rt = !id_use_imm;
        if (flush || !id_valid || !m.v || !m.mr || m.rd == 0) return 1'b0;
        return (m.rd == id_rs) || (reads_rt && m.rd == id_rt);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] ea, eb;
        #1;
        ea = m.us ? {27'b0, m.sh} : resolve(m.rs, m.rsd);
        eb = m.ui ? m.imm : resolve(m.rt, m.rtd);
        chk({tag, "/Ain"}, Ain, ea);
        chk({tag, "/Bin"}, Bin, eb);
        chk({tag, "/op"}, DW'(ALUControl), DW'(m.op));
        chk({tag, "/ex_valid"}, DW'(ex_valid), DW'(m.v));
        chk({tag, "/ex_rd"}, DW'(ex_rd), DW'(m.rd));
        chk({tag, "/ex_mem_read"}, DW'(ex_mem_read), DW'(m.mr));
        chk({tag, "/ex_reg_write"}, DW'(ex_reg_write), DW'(m.rw));
        chk({tag, "/stall"}, DW'(stall_id), DW'(exp_stall()));
        chk({tag, "/cnt"}, DW'(bubble_cnt), DW'(m_cnt));
    endtask

    // Advance one clock, updating the model from what ID/control present now.
    task automatic advance();
        logic st;
        st = exp_stall();
        if (RST) begin
            m = '0; m_cnt = 0;
        end else if (flush || st) begin
            m = '0;
            if (m_cnt < 65535) m_cnt++;
        end else if (id_valid) begin
            m = {id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
                 id_use_imm, id_shamt, id_use_shamt, id_mem_read, id_reg_write};
        end else begin
            m = '0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic [3:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                          input logic [DW-1:0] imm, input logic ui, input logic [4:0] sh,
                          input logic us, input logic mr, input logic rw);
        id_valid = 1'b1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui;
        id_shamt = sh; id_use_shamt = us; id_mem_read = mr; id_reg_write = rw;
    endtask

    task automatic clr_all();
        set_id(4'h0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0; flush = 1'b0;
        exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic reset_pulse();
        RST = 1'b1; clr_all(); advance(); RST = 1'b0;
    endtask

    initial begin
        m = '0; m_cnt = 0;
        RST = 1'b1;
        clr_all();

        // Reset held two cycles while ID offers a valid instruction
        set_id(4'b0010, 1, 2, 3, 32'h5, 32'h6, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        advance(); advance();
        check_all("reset");
        chk("reset/Ain0", Ain, 32'h0);
        chk("reset/ex_valid0", DW'(ex_valid), 32'h0);
        RST = 1'b0; clr_all();

        // Forwarding priority
        set_id(4'b0010, 5, 6, 1, 32'h99, 32'h77, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        advance();
        id_valid = 1'b0;
        exm_reg_write = 1'b1; exm_rd = 5; exm_result = 32'h11;
        wb_reg_write = 1'b1; wb_rd = 5; wb_data = 32'h22;
        check_all("fwd_exm");
        chk("fwd_exm/const", Ain, 32'h11);
        exm_reg_write = 1'b0;
        check_all("fwd_wb");
        chk("fwd_wb/const", Ain, 32'h22);
        exm_reg_write = 1'b1; exm_rd = 0; wb_rd = 0;
        set_id(4'b0010, 0, 6, 1, 32'h0, 32'h77, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        advance();
        id_valid = 1'b0;
        check_all("fwd_r0");
        chk("fwd_r0/const", Ain, 32'h0);

        // Load-use stall
        reset_pulse();
        set_id(4'b0010, 1, 2, 3, 32'h10, 32'h20, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        advance();
        set_id(4'b0010, 3, 4, 5, 32'h30, 32'h40, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check_all("lu_hz");
        chk("lu_hz/stall1", DW'(stall_id), 32'h1);
        advance();
        check_all("lu_bubble");
        chk("lu_bubble/ex_valid0", DW'(ex_valid), 32'h0);
        chk("lu_bubble/cnt1", DW'(bubble_cnt), 32'h1);
        advance();
        id_valid = 1'b0;
        check_all("lu_issue");
        chk("lu_issue/ex_rd", DW'(ex_rd), 32'h5);

        // Flush in the hazard cycle
        reset_pulse();
        set_id(4'b0010, 1, 2, 3, 32'h10, 32'h20, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        advance();
        set_id(4'b0010, 3, 4, 5, 32'h30, 32'h40, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        check_all("fl_hz");
        chk("fl_hz/stall0", DW'(stall_id), 32'h0);
        advance();
        flush = 1'b0; id_valid = 1'b0;
        check_all("fl_bubble");
        chk("fl_bubble/cnt1", DW'(bubble_cnt), 32'h1);
        advance();
        check_all("fl_after");

        // Shift and immediate operands
        clr_all();
        set_id(4'b0100, 0, 9, 2, 32'h0, 32'h1, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        advance();
        id_valid = 1'b0;
        check_all("sll");
        chk("sll/Ain", Ain, 32'h4);
        chk("sll/Bin", Bin, 32'h1);
        chk("sll/op", DW'(ALUControl), 32'h4);
        set_id(4'b0010, 1, 2, 7, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        advance();
        set_id(4'b0010, 2, 7, 8, 32'h3, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        check_all("addi_hz");
        chk("addi_hz/stall0", DW'(stall_id), 32'h0);
        advance();
        id_valid = 1'b0;
        check_all("addi");
        chk("addi/Bin", Bin, 32'hFFFF_FFFF);

        // Random traffic on a small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_id(4'($urandom), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                   AW'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 3) == 0), 5'($urandom), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 2) == 0), 1'($urandom));
            id_valid = ($urandom_range(0, 4) != 0);
            exm_reg_write = 1'($urandom); exm_rd = AW'($urandom_range(0, 3)); exm_result = $urandom;
            wb_reg_write = 1'($urandom); wb_rd = AW'($urandom_range(0, 3)); wb_data = $urandom;
            check_all("rand");
            advance();
        end
        RST = 1'b0;

        // Saturation and reset overriding a flush
        reset_pulse();
        flush = 1'b1;
        for (int i = 0; i < 65539; i++) advance();
        check_all("sat");
        chk("sat/cnt", DW'(bubble_cnt), 32'hFFFF);
        RST = 1'b1;
        advance();
        RST = 1'b0; flush = 1'b0;
        check_all("rst_flush");
        chk("rst_flush/cnt0", DW'(bubble_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
